// File: rtl/trax_forced_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : trax_forced_move_scheduler
// Purpose  : Walks every cell of the Trax board and places forced tiles. For
//            each empty cell it reads the facing edge of the four neighbours
//            and runs one tile_check evaluation. A non-empty result is written
//            back to the board. Passes repeat until one pass places nothing.
//            The block aborts with an error on a contradiction, a checker
//            timeout or when the pass limit is reached.
// Ports    : clk, rst_n                     - clock, async active-low reset
//            scan_start/busy/done/error     - scan control and status
//            placed_count                   - tiles placed by the last scan
//            rd_en/rd_addr/rd_side          - board read request
//            rd_edge/rd_occ                 - board read data (1 cycle later)
//            wr_en/wr_addr/wr_tile          - board write
//            chk_start, chk_up/down/right/left, chk_done, chk_tile
//                                           - tile_check handshake
// Revision : 1.0 - initial release
// ============================================================================
module trax_forced_move_scheduler #(
    parameter int BOARD_W     = 8,
    parameter int BOARD_H     = 8,
    parameter int ADDR_W      = 6,
    parameter int MAX_PASSES  = 16,
    parameter int CHK_TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_done,
    output logic              scan_error,
    output logic [7:0]        placed_count,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_side,
    output logic              rd_en,
    input  logic [2:0]        rd_edge,
    input  logic              rd_occ,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [5:0]        wr_tile,
    output logic              chk_start,
    output logic [2:0]        chk_up,
    output logic [2:0]        chk_down,
    output logic [2:0]        chk_right,
    output logic [2:0]        chk_left,
    input  logic              chk_done,
    input  logic [5:0]        chk_tile
);

    localparam int COL_W  = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
    localparam int ROW_W  = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
    localparam int PASS_W = (MAX_PASSES > 1) ? $clog2(MAX_PASSES) : 1;
    localparam int TMO_W  = (CHK_TIMEOUT > 2) ? $clog2(CHK_TIMEOUT) : 1;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(BOARD_W * BOARD_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(BOARD_W);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(BOARD_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(BOARD_H - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(MAX_PASSES - 1);
    // Error is reported CHK_TIMEOUT cycles after chk_start: the CHK cycle plus
    // CHK_TIMEOUT-1 cycles in CHK_WAIT, the last of which moves to ERR.
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(CHK_TIMEOUT - 2);

    localparam logic [1:0] SIDE_UP    = 2'd0;
    localparam logic [1:0] SIDE_DOWN  = 2'd1;
    localparam logic [1:0] SIDE_RIGHT = 2'd2;
    localparam logic [1:0] SIDE_LEFT  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_SELF_RD  = 4'd1,
        S_SELF_WT  = 4'd2,
        S_NB_RD    = 4'd3,
        S_CHK      = 4'd4,
        S_CHK_WAIT = 4'd5,
        S_WRITE    = 4'd6,
        S_NEXT     = 4'd7,
        S_PASS_END = 4'd8,
        S_DONE     = 4'd9,
        S_ERR      = 4'd10
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cell_q, cell_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic                pass_placed_q, pass_placed_d;
    logic [2:0]          nb_idx_q, nb_idx_d;
    logic                rd_pend_q, rd_pend_d;
    logic [3:0][2:0]     nb_q, nb_d;        // index = side slot: up,down,right,left
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [5:0]          tile_q, tile_d;
    logic [7:0]          placed_q, placed_d;
    logic                error_q, error_d;

    // Neighbour geometry for the current cell. Each neighbour is asked for
    // the edge that faces back toward the current cell.
    logic [3:0]              w_has;
    logic [3:0][ADDR_W-1:0]  w_nb_addr;
    logic [3:0][1:0]         w_nb_side;
    logic [1:0]              w_slot;
    logic [2:0]              w_cap;

    always_comb begin
        w_has[0]     = (row_q != '0);
        w_has[1]     = (row_q != ROW_LAST);
        w_has[2]     = (col_q != COL_LAST);
        w_has[3]     = (col_q != '0);
        w_nb_addr[0] = cell_q - ROW_STEP;
        w_nb_addr[1] = cell_q + ROW_STEP;
        w_nb_addr[2] = cell_q + ADDR_W'(1);
        w_nb_addr[3] = cell_q - ADDR_W'(1);
        w_nb_side[0] = SIDE_DOWN;
        w_nb_side[1] = SIDE_UP;
        w_nb_side[2] = SIDE_LEFT;
        w_nb_side[3] = SIDE_RIGHT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cell_q        <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pass_q        <= '0;
            pass_placed_q <= 1'b0;
            nb_idx_q      <= '0;
            rd_pend_q     <= 1'b0;
            nb_q          <= '0;
            tmo_q         <= '0;
            tile_q        <= '0;
            placed_q      <= '0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cell_q        <= cell_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pass_q        <= pass_d;
            pass_placed_q <= pass_placed_d;
            nb_idx_q      <= nb_idx_d;
            rd_pend_q     <= rd_pend_d;
            nb_q          <= nb_d;
            tmo_q         <= tmo_d;
            tile_q        <= tile_d;
            placed_q      <= placed_d;
            error_q       <= error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cell_d        = cell_q;
        col_d         = col_q;
        row_d         = row_q;
        pass_d        = pass_q;
        pass_placed_d = pass_placed_q;
        nb_idx_d      = nb_idx_q;
        rd_pend_d     = rd_pend_q;
        nb_d          = nb_q;
        tmo_d         = tmo_q;
        tile_d        = tile_q;
        placed_d      = placed_q;
        error_d       = error_q;
        rd_en         = 1'b0;
        rd_addr       = '0;
        rd_side       = SIDE_UP;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_tile       = '0;
        chk_start     = 1'b0;
        w_slot        = 2'(nb_idx_q - 3'd1);
        w_cap         = rd_pend_q ? rd_edge : 3'b000;

        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    placed_d      = '0;
                    error_d       = 1'b0;
                    cell_d        = '0;
                    col_d         = '0;
                    row_d         = '0;
                    pass_d        = '0;
                    pass_placed_d = 1'b0;
                    state_d       = S_SELF_RD;
                end
            end
            S_SELF_RD: begin
                rd_en   = 1'b1;
                rd_addr = cell_q;
                state_d = S_SELF_WT;
            end
            S_SELF_WT: begin
                nb_idx_d  = '0;
                rd_pend_d = 1'b0;
                state_d   = rd_occ ? S_NEXT : S_NB_RD;
            end
            S_NB_RD: begin
                // Slots 0..3 issue reads; each cycle from 1..4 captures the
                // read issued the cycle before. Off-board slots issue nothing
                // and capture 000.
                if (nb_idx_q != 3'd4) begin
                    rd_en     = w_has[nb_idx_q[1:0]];
                    rd_addr   = w_nb_addr[nb_idx_q[1:0]];
                    rd_side   = w_nb_side[nb_idx_q[1:0]];
                    rd_pend_d = w_has[nb_idx_q[1:0]];
                    nb_idx_d  = nb_idx_q + 3'd1;
                end else begin
                    rd_pend_d = 1'b0;
                end
                if (nb_idx_q != 3'd0) begin
                    nb_d[w_slot] = w_cap;
                end
                if (nb_idx_q == 3'd4) begin
                    if ((nb_q[0] | nb_q[1] | nb_q[2] | w_cap) == 3'b000) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                chk_start = 1'b1;
                tmo_d     = '0;
                state_d   = S_CHK_WAIT;
            end
            S_CHK_WAIT: begin
                if (chk_done) begin
                    tile_d = chk_tile;
                    if (chk_tile == 6'h00) begin
                        state_d = S_NEXT;
                    end else if (chk_tile == 6'h3F) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_WRITE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WRITE: begin
                wr_en         = 1'b1;
                wr_addr       = cell_q;
                wr_tile       = tile_q;
                pass_placed_d = 1'b1;
                if (placed_q != 8'hFF) begin
                    placed_d = placed_q + 8'd1;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (cell_q == LAST_CELL) begin
                    state_d = S_PASS_END;
                end else begin
                    cell_d = cell_q + ADDR_W'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    state_d = S_SELF_RD;
                end
            end
            S_PASS_END: begin
                if (!pass_placed_q) begin
                    state_d = S_DONE;
                end else if (pass_q == PASS_LAST) begin
                    state_d = S_ERR;
                end else begin
                    pass_d        = pass_q + PASS_W'(1);
                    cell_d        = '0;
                    col_d         = '0;
                    row_d         = '0;
                    pass_placed_d = 1'b0;
                    state_d       = S_SELF_RD;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Raise the error flag on entry so it is already high during the
        // scan_done pulse.
        if (state_d == S_ERR) begin
            error_d = 1'b1;
        end
    end

    assign scan_busy    = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
    assign scan_done    = (state_q == S_DONE) || (state_q == S_ERR);
    assign scan_error   = error_q;
    assign placed_count = placed_q;
    assign chk_up       = nb_q[0];
    assign chk_down     = nb_q[1];
    assign chk_right    = nb_q[2];
    assign chk_left     = nb_q[3];

endmodule
`default_nettype wire

// File: tb/tb_trax_forced_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_trax_forced_move_scheduler
// Purpose  : Self-checking bench for trax_forced_move_scheduler. A board RAM
//            model and a scripted tile_check model drive the DUT; expected
//            checker requests, board writes and scan completions are queued
//            by the stimulus and compared by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trax_forced_move_scheduler;

    localparam int BOARD_W     = 8;
    localparam int BOARD_H     = 8;
    localparam int ADDR_W      = 6;
    localparam int MAX_PASSES  = 16;
    localparam int CHK_TIMEOUT = 32;
    localparam int NCELL       = BOARD_W * BOARD_H;

    logic              clk;
    logic              rst_n;
    logic              scan_start;
    logic              scan_busy;
    logic              scan_done;
    logic              scan_error;
    logic [7:0]        placed_count;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_side;
    logic              rd_en;
    logic [2:0]        rd_edge;
    logic              rd_occ;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [5:0]        wr_tile;
    logic              chk_start;
    logic [2:0]        chk_up, chk_down, chk_right, chk_left;
    logic              chk_done;
    logic [5:0]        chk_tile;

    trax_forced_move_scheduler #(
        .BOARD_W    (BOARD_W),
        .BOARD_H    (BOARD_H),
        .ADDR_W     (ADDR_W),
        .MAX_PASSES (MAX_PASSES),
        .CHK_TIMEOUT(CHK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_start  (scan_start),
        .scan_busy   (scan_busy),
        .scan_done   (scan_done),
        .scan_error  (scan_error),
        .placed_count(placed_count),
        .rd_addr     (rd_addr),
        .rd_side     (rd_side),
        .rd_en       (rd_en),
        .rd_edge     (rd_edge),
        .rd_occ      (rd_occ),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_tile     (wr_tile),
        .chk_start   (chk_start),
        .chk_up      (chk_up),
        .chk_down    (chk_down),
        .chk_right   (chk_right),
        .chk_left    (chk_left),
        .chk_done    (chk_done),
        .chk_tile    (chk_tile)
    );

    // Scoreboard queues
    logic [11:0] exp_chk[$];   // {up,down,right,left}
    logic [11:0] exp_wr[$];    // {addr,tile}
    logic [8:0]  exp_done[$];  // {placed_count,scan_error}
    logic [5:0]  chk_resp[$];  // scripted tile_check answers

    int checks;
    int errors;
    int cyc;
    int chk_cyc;
    int exp_lat;
    int rd_cnt;
    int done_cnt;

    // Board model
    logic [2:0] edg [NCELL][4];
    logic       occ [NCELL];
    logic       sticky;        // when set, writes do not occupy cells

    function automatic logic [11:0] nb(input int u, input int d, input int r, input int l);
        return {3'(u), 3'(d), 3'(r), 3'(l)};
    endfunction

    function automatic logic [8:0] dn(input int pc, input int err);
        return {8'(pc), 1'(err)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_board();
        for (int c = 0; c < NCELL; c++) begin
            occ[c] = 1'b0;
            for (int s = 0; s < 4; s++) edg[c][s] = 3'b000;
        end
    endtask

    // Cell 1 occupied, only its down edge coloured: only cell 9 sees it.
    task automatic board_cell1_down();
        clear_board();
        occ[1]    = 1'b1;
        edg[1][1] = 3'b001;
    endtask

    task automatic start_scan();
        @(posedge clk);
        #1 scan_start = 1'b1;
        @(posedge clk);
        #1 scan_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != base) break;
        end
        #1;
        check("scan_done_seen", done_cnt - base, 1);
    endtask

    task automatic check_leftovers(input string tag);
        check({tag, "_left_chk"},  exp_chk.size(),  0);
        check({tag, "_left_wr"},   exp_wr.size(),   0);
        check({tag, "_left_done"}, exp_done.size(), 0);
        chk_resp.delete();
        exp_chk.delete();
        exp_wr.delete();
        exp_done.delete();
    endtask

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Board RAM model: request sampled mid-cycle, data presented just after
    // the next edge. Idle cycles present junk so stale captures show up.
    initial begin
        logic              r_en, w_en;
        logic [ADDR_W-1:0] r_a, w_a;
        logic [1:0]        r_s;
        rd_edge = 3'b000;
        rd_occ  = 1'b0;
        forever begin
            @(negedge clk);
            r_en = rd_en;
            r_a  = rd_addr;
            r_s  = rd_side;
            w_en = wr_en;
            w_a  = wr_addr;
            @(posedge clk);
            #1;
            if (w_en && !sticky) begin
                occ[w_a] = 1'b1;
                for (int s = 0; s < 4; s++) edg[w_a][s] = 3'b000;
            end
            if (r_en) begin
                rd_edge = edg[r_a][r_s];
                rd_occ  = occ[r_a];
            end else begin
                rd_edge = 3'b111;
                rd_occ  = 1'b1;
            end
        end
    end

    // tile_check model: answers after 3 cycles if a response is scripted,
    // otherwise stays silent.
    initial begin
        logic [5:0] r;
        chk_done = 1'b0;
        chk_tile = 6'h00;
        forever begin
            @(negedge clk);
            if (chk_start && rst_n && chk_resp.size() != 0) begin
                r = chk_resp.pop_front();
                repeat (3) @(posedge clk);
                #1;
                chk_done = 1'b1;
                chk_tile = r;
                @(posedge clk);
                #1;
                chk_done = 1'b0;
                chk_tile = 6'h00;
            end
        end
    end

    // Monitor
    initial begin
        logic [11:0] e12;
        logic [8:0]  e9;
        forever begin
            @(negedge clk);
            if (rd_en) rd_cnt++;
            if (chk_start) begin
                chk_cyc = cyc;
                if (exp_chk.size() == 0) begin
                    check("chk_unexpected", 1, 0);
                end else begin
                    e12 = exp_chk.pop_front();
                    check("chk_neighbours", {chk_up, chk_down, chk_right, chk_left}, e12);
                end
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    e12 = exp_wr.pop_front();
                    check("wr_addr_tile", {wr_addr, wr_tile}, e12);
                end
            end
            if (scan_done) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e9 = exp_done.pop_front();
                    check("done_placed", placed_count, e9[8:1]);
                    check("done_error", scan_error, e9[0]);
                    check("done_busy", scan_busy, 0);
                end
                if (exp_lat >= 0) begin
                    check("timeout_latency", cyc - chk_cyc, exp_lat);
                    exp_lat = -1;
                end
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        exp_lat    = -1;
        rd_cnt     = 0;
        done_cnt   = 0;
        chk_cyc    = 0;
        sticky     = 1'b0;
        scan_start = 1'b0;
        rst_n      = 1'b0;
        clear_board();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",   scan_busy,    0);
        check("rst_done",   scan_done,    0);
        check("rst_error",  scan_error,   0);
        check("rst_placed", placed_count, 0);
        check("rst_rd_en",  rd_en,        0);
        check("rst_wr_en",  wr_en,        0);
        check("rst_chk",    chk_start,    0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Empty board: one pass, 64 self reads + 224 neighbour reads, no checks
        rd_cnt = 0;
        exp_done.push_back(dn(0, 0));
        start_scan();
        repeat (20) @(negedge clk);
        check("busy_mid_scan", scan_busy, 1);
        start_scan();  // ignored while busy
        wait_done(2000);
        check("empty_rd_count", rd_cnt, 288);
        check_leftovers("empty");

        // Cell 1 has left edge 010 and down edge 001: cell 0 sees right=010
        // (no force), cell 9 sees up=001 and is forced to 05.
        clear_board();
        occ[1]    = 1'b1;
        edg[1][3] = 3'b010;
        edg[1][1] = 3'b001;
        exp_chk.push_back(nb(0, 0, 2, 0));
        exp_chk.push_back(nb(1, 0, 0, 0));
        exp_chk.push_back(nb(0, 0, 2, 0));
        chk_resp.push_back(6'h00);
        chk_resp.push_back(6'h05);
        chk_resp.push_back(6'h00);
        exp_wr.push_back({6'd9, 6'h05});
        exp_done.push_back(dn(1, 0));
        start_scan();
        wait_done(4000);
        check_leftovers("force");

        // Contradiction: error, no write
        board_cell1_down();
        exp_chk.push_back(nb(1, 0, 0, 0));
        chk_resp.push_back(6'h3F);
        exp_done.push_back(dn(0, 1));
        start_scan();
        wait_done(2000);
        repeat (2) @(negedge clk);
        check("error_level_held", scan_error, 1);
        check_leftovers("contra");

        // Checker never answers: error exactly CHK_TIMEOUT after chk_start
        board_cell1_down();
        exp_chk.push_back(nb(1, 0, 0, 0));
        exp_done.push_back(dn(0, 1));
        exp_lat = CHK_TIMEOUT;
        start_scan();
        @(negedge clk);
        check("error_cleared_on_start", scan_error, 0);
        wait_done(2000);
        check_leftovers("timeout");

        // Writes never stick: every pass forces cell 9 again -> pass limit
        board_cell1_down();
        sticky = 1'b1;
        for (int p = 0; p < MAX_PASSES; p++) begin
            exp_chk.push_back(nb(1, 0, 0, 0));
            chk_resp.push_back(6'h05);
            exp_wr.push_back({6'd9, 6'h05});
        end
        exp_done.push_back(dn(MAX_PASSES, 1));
        start_scan();
        wait_done(20000);
        sticky = 1'b0;
        check_leftovers("passlim");

        // Reset during CHK_WAIT, then a clean scan
        board_cell1_down();
        exp_chk.push_back(nb(1, 0, 0, 0));
        start_scan();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_chk.size() == 0) break;
        end
        check("reset_reached_chk", exp_chk.size(), 0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",   scan_busy, 0);
        check("arst_done",   scan_done, 0);
        check("arst_chk_up", chk_up,    0);
        check("arst_rd_en",  rd_en,     0);
        check("arst_chk",    chk_start, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        board_cell1_down();
        exp_chk.push_back(nb(1, 0, 0, 0));
        chk_resp.push_back(6'h05);
        exp_wr.push_back({6'd9, 6'h05});
        exp_done.push_back(dn(1, 0));
        start_scan();
        wait_done(4000);
        check_leftovers("after_rst");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
